// File: rtl/io_port_bridge_if.sv
`default_nettype none
// ============================================================================
// io_port_bridge_if
// Mesh-side and host-side signals of one io_port_bridge instance.
// Revision: 1.0
// ============================================================================
interface io_port_bridge_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 3,
    parameter int HOLD_WIDTH = 4
);
    logic                  io_active_out;
    logic [DATA_WIDTH-1:0] io_data_out;
    logic                  io_active_in;
    logic [DATA_WIDTH-1:0] io_data_in;
    logic [HOLD_WIDTH-1:0] hold_cycles;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic [CNT_WIDTH-1:0]  rx_count;
    logic                  rx_overflow;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [CNT_WIDTH-1:0]  tx_count;
    logic                  clear_overflow;

    modport slave (
        input  io_active_out, io_data_out, hold_cycles, rx_ready,
               tx_valid, tx_data, clear_overflow,
        output io_active_in, io_data_in, rx_valid, rx_data, rx_count,
               rx_overflow, tx_ready, tx_count
    );

    modport master (
        output io_active_out, io_data_out, hold_cycles, rx_ready,
               tx_valid, tx_data, clear_overflow,
        input  io_active_in, io_data_in, rx_valid, rx_data, rx_count,
               rx_overflow, tx_ready, tx_count
    );
endinterface
`default_nettype wire

// File: rtl/io_port_bridge.sv
`default_nettype none
// ============================================================================
// io_port_bridge
// External endpoint of a mem_mesh IO port: RX capture FIFO and timed TX FIFO.
// Revision: 1.0
// ============================================================================

module io_port_bridge_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  wire                   clk,
    input  wire                   rst_n,
    input  wire                   push,
    input  wire                   pop,
    input  wire  [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CNT_WIDTH-1:0]  count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    // The caller guarantees push is never issued when full without a pop,
    // and pop never when empty, so count cannot leave 0..FIFO_DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

module io_port_bridge #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 3,
    parameter int HOLD_WIDTH = 4
) (
    input  wire               clk,
    input  wire               rst_n,
    io_port_bridge_if.slave   bus
);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } tx_state_t;

    // ------------------------------------------------------------------ RX
    logic                  rx_push, rx_pop, rx_full, rx_valid;
    logic [DATA_WIDTH-1:0] rx_head;
    logic [CNT_WIDTH-1:0]  rx_count;
    logic                  rx_overflow_q, rx_overflow_d;

    assign rx_valid = (rx_count != '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_pop   = rx_valid && bus.rx_ready;
    assign rx_push  = bus.io_active_out && (!rx_full || rx_pop);

    io_port_bridge_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (bus.io_data_out),
        .rdata (rx_head),
        .count (rx_count)
    );

    // A new drop beats a same-cycle clear so no overflow event is lost.
    always_comb begin
        rx_overflow_d = rx_overflow_q;
        if (bus.clear_overflow) begin
            rx_overflow_d = 1'b0;
        end
        if (bus.io_active_out && rx_full && !rx_pop) begin
            rx_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overflow_q <= 1'b0;
        end else begin
            rx_overflow_q <= rx_overflow_d;
        end
    end

    assign bus.rx_valid    = rx_valid;
    assign bus.rx_data     = rx_head;
    assign bus.rx_count    = rx_count;
    assign bus.rx_overflow = rx_overflow_q;

    // ------------------------------------------------------------------ TX
    logic                  tx_push, tx_pop, tx_ready, tx_nonempty;
    logic [DATA_WIDTH-1:0] tx_head;
    logic [CNT_WIDTH-1:0]  tx_count;
    logic [HOLD_WIDTH-1:0] hold_load;

    tx_state_t             state_q, state_d;
    logic [HOLD_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] present_q, present_d;

    assign tx_ready    = (tx_count != FULL_CNT);
    assign tx_nonempty = (tx_count != '0);
    assign tx_push     = bus.tx_valid && tx_ready;
    assign hold_load   = (bus.hold_cycles == '0) ? HOLD_WIDTH'(1) : bus.hold_cycles;

    io_port_bridge_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (bus.tx_data),
        .rdata (tx_head),
        .count (tx_count)
    );

    // Reloading on the last hold cycle keeps io_active_in high between words.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        present_d = present_q;
        tx_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_nonempty) begin
                    tx_pop    = 1'b1;
                    present_d = tx_head;
                    hold_d    = hold_load;
                    state_d   = PRESENT;
                end
            end
            PRESENT: begin
                if (hold_q <= HOLD_WIDTH'(1)) begin
                    if (tx_nonempty) begin
                        tx_pop    = 1'b1;
                        present_d = tx_head;
                        hold_d    = hold_load;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q - HOLD_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            present_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            present_q <= present_d;
        end
    end

    assign bus.io_active_in = (state_q == PRESENT);
    assign bus.io_data_in   = present_q;
    assign bus.tx_ready     = tx_ready;
    assign bus.tx_count     = tx_count;
endmodule
`default_nettype wire

// File: tb/tb_io_port_bridge.sv
`default_nettype none
// ============================================================================
// tb_io_port_bridge
// Directed self-checking bench for io_port_bridge.
// Revision: 1.0
// ============================================================================
module tb_io_port_bridge;
    localparam int DATA_WIDTH = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_WIDTH  = 3;
    localparam int HOLD_WIDTH = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    io_port_bridge_if #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .HOLD_WIDTH (HOLD_WIDTH)
    ) bus ();

    io_port_bridge #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .HOLD_WIDTH (HOLD_WIDTH)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  cyc;
        bit  seen_active;
        total = 0;
        bad   = 0;

        rst_n              = 1'b0;
        bus.io_active_out  = 1'b0;
        bus.io_data_out    = '0;
        bus.hold_cycles    = '0;
        bus.rx_ready       = 1'b0;
        bus.tx_valid       = 1'b0;
        bus.tx_data        = '0;
        bus.clear_overflow = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();

        check("rst_rx_valid",    32'(bus.rx_valid),     0);
        check("rst_active_in",   32'(bus.io_active_in), 0);
        check("rst_data_in",     32'(bus.io_data_in),   0);
        check("rst_tx_ready",    32'(bus.tx_ready),     1);
        check("rst_rx_count",    32'(bus.rx_count),     0);
        check("rst_tx_count",    32'(bus.tx_count),     0);
        check("rst_rx_overflow", 32'(bus.rx_overflow),  0);

        // RX capture of three words, host not ready
        bus.io_active_out = 1'b1;
        bus.io_data_out   = 16'd100;
        step();
        check("rx_lat1_valid", 32'(bus.rx_valid), 1);
        check("rx_lat1_data",  32'(bus.rx_data),  100);
        bus.io_data_out = 16'd200;
        step();
        bus.io_data_out = 16'd300;
        step();
        bus.io_active_out = 1'b0;
        check("rx_cap_count", 32'(bus.rx_count), 3);
        check("rx_cap_head",  32'(bus.rx_data),  100);
        bus.rx_ready = 1'b1;
        check("rx_rd0", 32'(bus.rx_data), 100);
        step();
        check("rx_rd1", 32'(bus.rx_data), 200);
        step();
        check("rx_rd2", 32'(bus.rx_data), 300);
        step();
        bus.rx_ready = 1'b0;
        check("rx_drained_valid", 32'(bus.rx_valid), 0);
        check("rx_drained_count", 32'(bus.rx_count), 0);

        // RX overflow: five strobes into a four-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            bus.io_active_out = 1'b1;
            bus.io_data_out   = 16'(i);
            step();
        end
        bus.io_active_out = 1'b0;
        check("ovf_count", 32'(bus.rx_count),    4);
        check("ovf_flag",  32'(bus.rx_overflow), 1);
        check("ovf_head",  32'(bus.rx_data),     1);
        // Full with simultaneous pop: write accepted
        bus.io_active_out = 1'b1;
        bus.io_data_out   = 16'd6;
        bus.rx_ready      = 1'b1;
        step();
        bus.io_active_out = 1'b0;
        bus.rx_ready      = 1'b0;
        check("full_pop_count", 32'(bus.rx_count),    4);
        check("full_pop_head",  32'(bus.rx_data),     2);
        check("full_pop_ovf",   32'(bus.rx_overflow), 1);
        bus.clear_overflow = 1'b1;
        step();
        bus.clear_overflow = 1'b0;
        check("ovf_cleared", 32'(bus.rx_overflow), 0);
        bus.rx_ready = 1'b1;
        check("ovf_rd2", 32'(bus.rx_data), 2);
        step();
        check("ovf_rd3", 32'(bus.rx_data), 3);
        step();
        check("ovf_rd4", 32'(bus.rx_data), 4);
        step();
        check("ovf_rd_tail6", 32'(bus.rx_data), 6);
        step();
        bus.rx_ready = 1'b0;
        check("ovf_empty", 32'(bus.rx_valid), 0);

        // TX presentation, hold 3; mid-presentation hold change must not apply
        bus.hold_cycles = 4'd3;
        bus.tx_valid    = 1'b1;
        bus.tx_data     = 16'd1234;
        step();
        bus.tx_valid = 1'b0;
        check("tx_n1_active", 32'(bus.io_active_in), 0);
        check("tx_n1_count",  32'(bus.tx_count),     1);
        step();
        check("tx_n2_active", 32'(bus.io_active_in), 1);
        check("tx_n2_data",   32'(bus.io_data_in),   1234);
        check("tx_n2_count",  32'(bus.tx_count),     0);
        bus.hold_cycles = 4'd9;
        step();
        check("tx_n3_active", 32'(bus.io_active_in), 1);
        step();
        check("tx_n4_active", 32'(bus.io_active_in), 1);
        step();
        check("tx_n5_active", 32'(bus.io_active_in), 0);
        check("tx_n5_hold_data", 32'(bus.io_data_in), 1234);

        // TX back-to-back with hold 0 (treated as 1)
        bus.hold_cycles = 4'd0;
        bus.tx_valid    = 1'b1;
        bus.tx_data     = 16'd7;
        step();
        bus.tx_data = 16'd8;
        step();
        bus.tx_data = 16'd9;
        check("b2b_7_active", 32'(bus.io_active_in), 1);
        check("b2b_7_data",   32'(bus.io_data_in),   7);
        step();
        bus.tx_valid = 1'b0;
        check("b2b_8_active", 32'(bus.io_active_in), 1);
        check("b2b_8_data",   32'(bus.io_data_in),   8);
        step();
        check("b2b_9_active", 32'(bus.io_active_in), 1);
        check("b2b_9_data",   32'(bus.io_data_in),   9);
        step();
        check("b2b_end_active", 32'(bus.io_active_in), 0);

        // TX full: long hold, five pushes leave four queued
        bus.hold_cycles = 4'd15;
        for (int i = 0; i < 5; i++) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 16'(10 + i);
            step();
        end
        bus.tx_valid = 1'b0;
        check("txfull_count", 32'(bus.tx_count), 4);
        check("txfull_ready", 32'(bus.tx_ready), 0);
        check("txfull_data",  32'(bus.io_data_in), 10);
        cyc = 0;
        while (!bus.tx_ready && cyc < 40) begin
            step();
            cyc++;
        end
        check("txfull_reready",      32'(bus.tx_ready),   1);
        check("txfull_reready_cyc",  32'(cyc),            12);
        check("txfull_next_data",    32'(bus.io_data_in), 11);
        check("txfull_after_count",  32'(bus.tx_count),   3);

        // Asynchronous reset in the middle of a presentation
        check("pre_rst_active", 32'(bus.io_active_in), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_active",   32'(bus.io_active_in), 0);
        check("mid_rst_data",     32'(bus.io_data_in),   0);
        check("mid_rst_tx_count", 32'(bus.tx_count),     0);
        check("mid_rst_tx_ready", 32'(bus.tx_ready),     1);
        check("mid_rst_rx_valid", 32'(bus.rx_valid),     0);
        repeat (2) step();
        rst_n = 1'b1;
        seen_active = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.io_active_in || bus.io_data_in != '0) seen_active = 1'b1;
        end
        check("post_rst_no_stale", 32'(seen_active),  0);
        check("post_rst_tx_count", 32'(bus.tx_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
